// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device as an
// 11-bit frame and checks the device ACK. The ps2c/ps2d lines are open-drain,
// so this block only ever pulls them low or releases them.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | lines released, waiting for wr_ps2
// RTS      | request-to-send: ps2c and ps2d held low for INHIBIT_CYCLES
// START    | ps2c released, ps2d low (start bit), waiting for first fall
// DATA     | ps2d follows sr[0]; shift on each fall, 8 data + parity
// STOP     | ps2d released (stop bit); 11th fall latches device ACK
// WAIT_REL | waiting for the device to release both lines
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  tri         ps2c,
  inout  tri         ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, WAIT_REL} state_t;

  state_t          state_q, state_d;
  logic [8:0]      sr_q, sr_d;
  logic [3:0]      n_q, n_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            c_low_q, c_low_d;
  logic            d_low_q, d_low_d;

  // index 0 = ps2c, index 1 = ps2d
  logic [1:0]      meta_q, sync_q, filt_q;
  logic [FW-1:0]   fcnt_q [2];
  logic            c_prev_q;
  logic            fall;
  logic            rel_done;

  assign ps2c = c_low_q ? 1'b0 : 1'bz;
  assign ps2d = d_low_q ? 1'b0 : 1'bz;

  assign tx_idle      = (state_q == IDLE);
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;

  assign fall     = c_prev_q & ~filt_q[0];
  assign rel_done = (state_q == WAIT_REL) && filt_q[0] && filt_q[1];

  // Synchronise both lines, then require FILTER_LEN equal samples to change level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q   <= 2'b11;
      sync_q   <= 2'b11;
      filt_q   <= 2'b11;
      fcnt_q   <= '{default: '0};
      c_prev_q <= 1'b1;
    end else begin
      meta_q   <= {ps2d, ps2c};
      sync_q   <= meta_q;
      c_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] != filt_q[i]) begin
          if (fcnt_q[i] == F_LAST) begin
            filt_q[i] <= sync_q[i];
            fcnt_q[i] <= '0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + 1'b1;
          end
        end else begin
          fcnt_q[i] <= '0;
        end
      end
    end
  end

  // State, frame, counters, registered line drives and ticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      n_q     <= '0;
      inh_q   <= '0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      c_low_q <= 1'b0;
      d_low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      n_q     <= n_d;
      inh_q   <= inh_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      c_low_q <= c_low_d;
      d_low_q <= d_low_d;
    end
  end

  // Next-state logic; the watchdog overrides the frame FSM when it expires.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    n_d     = n_q;
    inh_d   = inh_q;
    wd_d    = wd_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          sr_d    = {~^din, din};
          n_d     = '0;
          inh_d   = INH_LOAD;
          state_d = RTS;
        end
      end
      RTS: begin
        if (inh_q == '0) begin
          wd_d    = WD_LOAD;
          state_d = START;
        end else begin
          inh_d = inh_q - 1'b1;
        end
      end
      START: begin
        if (fall) state_d = DATA;
      end
      DATA: begin
        if (fall) begin
          if (n_q == 4'd8) begin
            state_d = STOP;
          end else begin
            sr_d = {1'b0, sr_q[8:1]};
            n_d  = n_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (fall) begin
          ack_d   = ~filt_q[1];
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (rel_done) begin
          state_d = IDLE;
          done_d  = ack_q;
          err_d   = ~ack_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished release takes priority over a watchdog expiring in the same cycle.
    if ((state_q inside {START, DATA, STOP, WAIT_REL}) && !rel_done) begin
      if (fall) begin
        wd_d = WD_LOAD;
      end else if (wd_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q - 1'b1;
      end
    end
  end

  // Line drives follow the next state so they change on the same edge as the FSM.
  always_comb begin
    c_low_d = (state_d == RTS);
    d_low_d = (state_d == RTS) || (state_d == START) ||
              ((state_d == DATA) && !sr_d[0]);
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: pull-ups on both lines and a behavioural PS/2 device that
// clocks the frame, samples data on rising edges and optionally ACKs.
module tb_ps2_tx;

  localparam int HALF = 40;

  logic       clk;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle, tx_done_tick, tx_err_tick;
  logic       dev_c, dev_d;
  wire        ps2c, ps2d;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c ? 1'b0 : 1'bz;
  assign ps2d = dev_d ? 1'b0 : 1'bz;

  ps2_tx #(.INHIBIT_CYCLES(100), .FILTER_LEN(8), .TIMEOUT_CYCLES(5000)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick (tx_err_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_err_tick === 1'b1) err_cnt <= err_cnt + 1;
    if (tx_done_tick === 1'b1 && tx_err_tick === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one frame and act as the device. glitch_k / wr_k / rst_k select the
  // device clock number at which a corner-case disturbance is injected (0 = none).
  task automatic run_frame(input logic [7:0] b, input bit nack, input int glitch_k,
                           input int wr_k, input int rst_k,
                           output logic [10:0] fr, output int low_cnt, output bit aborted);
    int t;
    fr      = '0;
    aborted = 1'b0;
    din     = b;
    wr_ps2  = 1'b1;
    @(posedge clk); #1;
    wr_ps2  = 1'b0;
    low_cnt = 0;
    while (ps2c !== 1'b1 && low_cnt < 1000) begin
      low_cnt++;
      @(posedge clk); #1;
    end
    wait_cyc(20);
    fr[0] = ps2d;
    for (int k = 1; k <= 11; k++) begin
      dev_c = 1'b1;
      wait_cyc(20);
      if (k == wr_k) begin
        wr_ps2 = 1'b1;
        din    = 8'h00;
        @(posedge clk); #1;
        wr_ps2 = 1'b0;
        din    = b;
        wait_cyc(HALF - 21);
      end else begin
        wait_cyc(HALF - 20);
      end
      dev_c = 1'b0;
      if (k <= 10) fr[k] = ps2d;
      if (k == rst_k) begin
        wait_cyc(20);
        chk("pre_reset_ps2d_low", int'(ps2d === 1'b0), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ps2c_released", int'(ps2c === 1'b1), 1);
        chk("rst_ps2d_released", int'(ps2d === 1'b1), 1);
        chk("rst_tx_idle", int'(tx_idle), 1);
        reset   = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (k == glitch_k) begin
        wait_cyc(15);
        dev_c = 1'b1;
        wait_cyc(3);
        dev_c = 1'b0;
        wait_cyc(HALF - 18);
      end else if (k == 10) begin
        wait_cyc(20);
        if (!nack) dev_d = 1'b1;
        wait_cyc(HALF - 20);
      end else if (k == 11) begin
        wait_cyc(20);
        dev_d = 1'b0;
        wait_cyc(HALF - 20);
      end else begin
        wait_cyc(HALF);
      end
    end
    t = 0;
    while (tx_idle !== 1'b1 && t < 500) begin
      t++;
      @(posedge clk); #1;
    end
    if (t >= 500) chk("idle_wait_bound", 0, 1);
  endtask

  typedef struct {
    logic [7:0]  din;
    bit          nack;
    logic [10:0] exp_frame;  // {stop, parity, d7..d0, start}
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [10:0] fr;
    int          low_cnt;
    bit          aborted;
    int          d0, e0, cyc;

    vecs[0] = '{8'hED, 1'b0, 11'b11_11101101_0, 1, 0};
    vecs[1] = '{8'h00, 1'b0, 11'b11_00000000_0, 1, 0};
    vecs[2] = '{8'hFF, 1'b0, 11'b11_11111111_0, 1, 0};
    vecs[3] = '{8'h01, 1'b0, 11'b10_00000001_0, 1, 0};
    vecs[4] = '{8'hED, 1'b1, 11'b11_11101101_0, 0, 1};
    vecs[5] = '{8'hA5, 1'b0, 11'b11_10100101_0, 1, 0};

    reset  = 1'b0;
    wr_ps2 = 1'b0;
    din    = 8'h00;
    dev_c  = 1'b0;
    dev_d  = 1'b0;
    wait_cyc(5);
    chk("reset_tx_idle", int'(tx_idle), 1);
    chk("reset_done_tick", int'(tx_done_tick), 0);
    chk("reset_err_tick", int'(tx_err_tick), 0);
    chk("reset_ps2c", int'(ps2c === 1'b1), 1);
    chk("reset_ps2d", int'(ps2d === 1'b1), 1);
    reset = 1'b1;
    wait_cyc(20);

    foreach (vecs[i]) begin
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(vecs[i].din, vecs[i].nack, 0, 0, 0, fr, low_cnt, aborted);
      wait_cyc(20);
      chk($sformatf("v%0d_frame", i), int'(fr), int'(vecs[i].exp_frame));
      chk($sformatf("v%0d_inhibit_len", i), low_cnt, 100);
      chk($sformatf("v%0d_done_ticks", i), done_cnt - d0, vecs[i].exp_done);
      chk($sformatf("v%0d_err_ticks", i), err_cnt - e0, vecs[i].exp_err);
      chk($sformatf("v%0d_idle", i), int'(tx_idle), 1);
    end

    // Device never clocks: watchdog fires 5000 clks after START entry (accept + 100).
    d0 = done_cnt;
    e0 = err_cnt;
    din    = 8'h3C;
    wr_ps2 = 1'b1;
    @(posedge clk); #1;
    wr_ps2 = 1'b0;
    cyc = 0;
    while (tx_err_tick !== 1'b1 && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("timeout_latency", cyc, 5100);
    chk("timeout_idle", int'(tx_idle), 1);
    chk("timeout_ps2c_released", int'(ps2c === 1'b1), 1);
    chk("timeout_ps2d_released", int'(ps2d === 1'b1), 1);
    wait_cyc(5);
    chk("timeout_err_ticks", err_cnt - e0, 1);
    chk("timeout_done_ticks", done_cnt - d0, 0);
    wait_cyc(20);

    // Reset while bit 4 of 0xED (a 0) is on the line.
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(8'hED, 1'b0, 0, 0, 5, fr, low_cnt, aborted);
    chk("rst_aborted", int'(aborted), 1);
    wait_cyc(300);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_err", err_cnt - e0, 0);
    chk("rst_still_idle", int'(tx_idle), 1);

    // Second wr_ps2 mid-frame is ignored and not queued.
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(8'hED, 1'b0, 0, 3, 0, fr, low_cnt, aborted);
    wait_cyc(50);
    chk("midwr_frame", int'(fr), int'(11'b11_11101101_0));
    chk("midwr_done_ticks", done_cnt - d0, 1);
    chk("midwr_err_ticks", err_cnt - e0, 0);
    chk("midwr_not_queued_idle", int'(tx_idle), 1);
    chk("midwr_not_queued_ps2c", int'(ps2c === 1'b1), 1);

    // Short low glitch on ps2c during DATA must not cause a shift.
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(8'h96, 1'b0, 5, 0, 0, fr, low_cnt, aborted);
    wait_cyc(20);
    chk("glitch_frame", int'(fr), int'(11'b11_10010110_0));
    chk("glitch_done_ticks", done_cnt - d0, 1);
    chk("glitch_err_ticks", err_cnt - e0, 0);

    chk("ticks_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

endmodule
